spi_rx_block_sched: RTL and testbench

//  Sequences 128-bit blocks from the 8-lane SPI slave receiver into the AES co-processor.

---
 rtl/spi_rx_block_sched.sv | 156 +++++++++++++++
 tb/tb_spi_rx_block_sched.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_block_sched.sv
// Block scheduler between the 8-lane SPI receiver and the AES core.
// Queues received blocks, dispatches one AES job at a time, parks results for the CPU.
module spi_rx_block_sched #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             rx_valid,
    input  logic [127:0]     rx_data,
    output logic             aes_start,
    output logic [127:0]     aes_din,
    input  logic             aes_done,
    input  logic [127:0]     aes_dout,
    output logic             res_valid,
    output logic [127:0]     res_data,
    input  logic             res_ready,
    input  logic             err_clr,
    output logic             err_timeout,
    output logic [PTR_W:0]   fifo_level,
    output logic [7:0]       drop_count,
    output logic             irq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0] lvl_q, lvl_d;
    logic [127:0]   din_q, din_d;
    logic [127:0]   res_q, res_d;
    logic [127:0]   hold_q, hold_d;
    logic           vld_q, vld_d;
    logic           err_q, err_d;
    logic [7:0]     drop_q, drop_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    logic pop, push, slot_free;

    assign pop       = (state_q == IDLE) && enable && (lvl_q != '0);
    // A full FIFO can still take a block when the head leaves this cycle
    assign push      = rx_valid && ((lvl_q != LVL_FULL) || pop);
    assign slot_free = !vld_q || res_ready;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        lvl_d  = lvl_q;
        drop_d = drop_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop) lvl_d = lvl_q + 1'b1;
        if (pop && !push) lvl_d = lvl_q - 1'b1;
        if (rx_valid && !push && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        res_d   = res_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        vld_d   = vld_q && !res_ready;
        err_d   = err_q;
        if (err_clr) err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    din_d   = mem_q[rd_q];
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (aes_done) begin
                    if (slot_free) begin
                        res_d   = aes_dout;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        hold_d  = aes_dout;
                        state_d = HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    res_d   = hold_q;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            din_q   <= '0;
            res_q   <= '0;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) mem_q[wr_q] <= rx_data;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            din_q   <= din_d;
            res_q   <= res_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
        end
    end

    assign aes_start   = (state_q == START);
    assign aes_din     = din_q;
    assign res_valid   = vld_q;
    assign res_data    = res_q;
    assign err_timeout = err_q;
    assign fifo_level  = lvl_q;
    assign drop_count  = drop_q;
    assign irq         = vld_q | err_q;

endmodule

// File: tb/tb_spi_rx_block_sched.sv
// Scoreboard bench for spi_rx_block_sched with a behavioural AES responder.
// Expected results (~block) are queued on push and compared as results appear.
module tb_spi_rx_block_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         rx_valid;
    logic [127:0] rx_data;
    logic         aes_start;
    logic [127:0] aes_din;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_ready;
    logic         err_clr;
    logic         err_timeout;
    logic [2:0]   fifo_level;
    logic [7:0]   drop_count;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;
    int starts = 0;
    int aes_lat = 10;
    bit inject = 1'b0;
    logic [127:0] exp_q [$];

    spi_rx_block_sched dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .aes_start(aes_start),
        .aes_din(aes_din),
        .aes_done(aes_done),
        .aes_dout(aes_dout),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_ready(res_ready),
        .err_clr(err_clr),
        .err_timeout(err_timeout),
        .fifo_level(fifo_level),
        .drop_count(drop_count),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (aes_start === 1'b1) starts++;

    // AES responder: done with dout=~din aes_lat cycles after start, 0 = never
    initial begin
        int cnt;
        bit last_inj;
        logic [127:0] lat_din;
        cnt = 0;
        last_inj = 1'b0;
        lat_din = '0;
        aes_done = 1'b0;
        aes_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            aes_done = 1'b0;
            if (reset === 1'b1) begin
                cnt = 0;
            end else if (inject != last_inj) begin
                last_inj = inject;
                aes_done = 1'b1;
                aes_dout = '1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    aes_done = 1'b1;
                    aes_dout = ~lat_din;
                end
            end else if (aes_start === 1'b1 && aes_lat > 0) begin
                lat_din = aes_din;
                cnt = aes_lat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic push_blk(input logic [127:0] d, input bit keep);
        rx_valid = 1'b1;
        rx_data  = d;
        if (keep) exp_q.push_back(~d);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        res_ready = 1'b0;
        err_clr = 1'b0;
        repeat (2) tick();
        checks++;
        if ({aes_start, res_valid, err_timeout, irq} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {aes_start, res_valid, err_timeout, irq});
        end
        checks++;
        if (aes_din !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_data: din %h res %h want 0", aes_din, res_data);
        end
        checks++;
        if (fifo_level !== 3'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: lvl %0d drop %0d want 0 0",
                     fifo_level, drop_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [127:0] d, e;
        int n;
        d = 128'h000102030405060708090a0b0c0d0e0f;
        enable = 1'b1;
        res_ready = 1'b0;
        aes_lat = 10;
        rx_valid = 1'b1;
        rx_data = d;
        exp_q.push_back(~d);
        tick();
        rx_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1 || aes_start !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: lvl %0d start %b want 1 0",
                     fifo_level, aes_start);
        end
        tick();
        checks++;
        if (aes_start !== 1'b1 || aes_din !== d) begin
            errors++;
            $display("FAIL single_t2: start %b din %h want 1 %h",
                     aes_start, aes_din, d);
        end
        wait_res(50, n);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL single_lat: got %0d cycles want 11", n);
        end
        e = pop_exp();
        checks++;
        if (res_data !== e || irq !== 1'b1) begin
            errors++;
            $display("FAIL single_res: got %h irq %b want %h 1", res_data, irq, e);
        end
        repeat (3) tick();
        checks++;
        if (res_valid !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL single_keep: vld %b irq %b want 1 1", res_valid, irq);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: vld %b irq %b want 0 0", res_valid, irq);
        end
    endtask

    task automatic test_burst();
        logic [127:0] e;
        int got;
        enable = 1'b0;
        res_ready = 1'b0;
        aes_lat = 4;
        for (int i = 0; i < 6; i++) push_blk(rnd128(), i < 4);
        exp_drops += 2;
        checks++;
        if (fifo_level !== 3'd4 || drop_count !== 8'(exp_drops)) begin
            errors++;
            $display("FAIL burst_fill: lvl %0d drop %0d want 4 %0d",
                     fifo_level, drop_count, exp_drops);
        end
        enable = 1'b1;
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 300 && got < 4; c++) begin
            tick();
            if (res_valid === 1'b1) begin
                got++;
                e = pop_exp();
                checks++;
                if (res_data !== e) begin
                    errors++;
                    $display("FAIL burst_data[%0d]: got %h want %h", got, res_data, e);
                end
            end
        end
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL burst_count: got %0d results want 4", got);
        end
        tick();
        checks++;
        if (fifo_level !== 3'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: lvl %0d vld %b want 0 0", fifo_level, res_valid);
        end
    endtask

    task automatic test_hold();
        logic [127:0] e;
        int base, n;
        res_ready = 1'b0;
        aes_lat = 3;
        base = starts;
        for (int i = 0; i < 3; i++) push_blk(rnd128(), 1'b1);
        repeat (40) tick();
        checks++;
        if (starts - base !== 2 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL hold_stall: starts %0d lvl %0d want 2 1",
                     starts - base, fifo_level);
        end
        e = pop_exp();
        checks++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            errors++;
            $display("FAIL hold_first: vld %b got %h want %h", res_valid, res_data, e);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        e = pop_exp();
        checks++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            errors++;
            $display("FAIL hold_second: vld %b got %h want %h", res_valid, res_data, e);
        end
        res_ready = 1'b1;
        tick();
        wait_res(50, n);
        e = pop_exp();
        checks++;
        if (res_valid !== 1'b1 || res_data !== e || starts - base !== 3) begin
            errors++;
            $display("FAIL hold_third: vld %b got %h want %h starts %0d",
                     res_valid, res_data, e, starts - base);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [127:0] e;
        int n;
        res_ready = 1'b1;
        aes_lat = 0;
        push_blk(rnd128(), 1'b0);
        n = 0;
        while (aes_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (aes_start !== 1'b1) begin
            errors++;
            $display("FAIL tmo_start: start %b want 1", aes_start);
        end
        aes_lat = 5;
        push_blk(rnd128(), 1'b1);
        n = 1;
        while (err_timeout !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 1025 || irq !== 1'b1) begin
            errors++;
            $display("FAIL tmo_cycles: got %0d irq %b want 1025 1", n, irq);
        end
        wait_res(50, n);
        e = pop_exp();
        checks++;
        if (res_valid !== 1'b1 || res_data !== e || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_next: vld %b got %h want %h err %b",
                     res_valid, res_data, e, err_timeout);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clr: err %b irq %b want 0 0", err_timeout, irq);
        end
        aes_lat = 1024;
        push_blk(rnd128(), 1'b1);
        wait_res(1100, n);
        e = pop_exp();
        checks++;
        if (res_valid !== 1'b1 || res_data !== e || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_edge: vld %b got %h want %h err %b",
                     res_valid, res_data, e, err_timeout);
        end
        tick();
    endtask

    task automatic test_full_pop();
        logic [127:0] e, d;
        int got;
        enable = 1'b0;
        res_ready = 1'b0;
        aes_lat = 3;
        for (int i = 0; i < 4; i++) push_blk(rnd128(), 1'b1);
        d = rnd128();
        enable = 1'b1;
        rx_valid = 1'b1;
        rx_data = d;
        exp_q.push_back(~d);
        tick();
        rx_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || drop_count !== 8'(exp_drops) || aes_start !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: lvl %0d drop %0d start %b want 4 %0d 1",
                     fifo_level, drop_count, aes_start, exp_drops);
        end
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 300 && got < 5; c++) begin
            tick();
            if (res_valid === 1'b1) begin
                got++;
                e = pop_exp();
                checks++;
                if (res_data !== e) begin
                    errors++;
                    $display("FAIL full_data[%0d]: got %h want %h", got, res_data, e);
                end
            end
        end
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL full_count: got %0d results want 5", got);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int base;
        enable = 1'b1;
        res_ready = 1'b0;
        aes_lat = 0;
        for (int i = 0; i < 4; i++) push_blk(rnd128(), 1'b0);
        repeat (3) tick();
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++;
            $display("FAIL rm_level: got %0d want 3", fifo_level);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({aes_start, res_valid, err_timeout, irq} !== 4'b0 ||
            fifo_level !== 3'd0 || aes_din !== '0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL rm_async: flags %b lvl %0d din %h drop %0d want 0",
                     {aes_start, res_valid, err_timeout, irq},
                     fifo_level, aes_din, drop_count);
        end
        exp_drops = 0;
        tick();
        reset = 1'b0;
        base = starts;
        inject = ~inject;
        repeat (5) tick();
        checks++;
        if (res_valid !== 1'b0 || starts - base !== 0 || res_data !== '0) begin
            errors++;
            $display("FAIL rm_late_done: vld %b starts %0d res %h want 0 0 0",
                     res_valid, starts - base, res_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_hold();
        test_timeout();
        test_full_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
